// File: rtl/bch_encoder_seq_pkg.sv
// Shared constants for the (542,512) t=3 binary BCH code over GF(2^10).
// The generator is derived at elaboration from the field polynomial.
package bch_encoder_seq_pkg;

   localparam int BCH_N = 542;
   localparam int BCH_K = 512;
   localparam int BCH_R = 30;
   localparam int BCH_M = 10;

   // Primitive field polynomial x^10 + x^3 + 1
   localparam logic [BCH_M:0] BCH_PRIM = 11'h409;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ENC  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic [BCH_M-1:0] gf_mul(input logic [BCH_M-1:0] a,
                                               input logic [BCH_M-1:0] b);
      logic [BCH_M-1:0] acc;
      logic [BCH_M-1:0] sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < BCH_M; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[BCH_M-2:0], 1'b0} ^ (sh[BCH_M-1] ? BCH_PRIM[BCH_M-1:0] : '0);
      end
      return acc;
   endfunction

   // g(x) = product of (x + r) over the cyclotomic cosets of alpha^1, alpha^3, alpha^5;
   // conjugates are reached by repeated squaring, so no power table is needed.
   function automatic logic [BCH_R:0] bch_gen_poly();
      logic [BCH_M*(BCH_R+1)-1:0] c;
      logic [BCH_M-1:0]           root;
      logic [BCH_M-1:0]           prev;
      logic [BCH_M-1:0]           cur;
      logic [BCH_R:0]             g;
      c = '0;
      c[0 +: BCH_M] = BCH_M'(1);
      for (int s = 0; s < 3; s++) begin
         root = BCH_M'(1 << (2 * s + 1));
         for (int k = 0; k < BCH_M; k++) begin
            for (int j = BCH_R; j >= 0; j--) begin
               cur  = c[j*BCH_M +: BCH_M];
               prev = '0;
               if (j > 0) prev = c[(j-1)*BCH_M +: BCH_M];
               c[j*BCH_M +: BCH_M] = prev ^ gf_mul(root, cur);
            end
            root = gf_mul(root, root);
         end
      end
      g = '0;
      for (int j = 0; j <= BCH_R; j++) g[j] = c[j*BCH_M];
      return g;
   endfunction

   localparam logic [BCH_R:0] BCH_GEN = bch_gen_poly();

endpackage

// File: rtl/bch_encoder_seq_lfsr_step.sv
// Combinational CHUNK-bit step of the parity-division LFSR, MSB of data first.
module bch_lfsr_step
   import bch_encoder_seq_pkg::*;
#(
   parameter int CHUNK = 32
) (
   input  logic [BCH_R-1:0] state_i,
   input  logic [CHUNK-1:0] data_i,
   output logic [BCH_R-1:0] state_o
);

   logic [BCH_R-1:0] s;
   logic             fb;

   always_comb begin
      s  = state_i;
      fb = 1'b0;
      for (int i = CHUNK - 1; i >= 0; i--) begin
         fb = s[BCH_R-1] ^ data_i[i];
         s  = {s[BCH_R-2:0], 1'b0} ^ ({BCH_R{fb}} & BCH_GEN[BCH_R-1:0]);
      end
      state_o = s;
   end

endmodule

// File: rtl/bch_encoder_seq.sv
// Sequential systematic BCH(542,512) encoder: absorbs CHUNK message bits per cycle,
// then presents {message, parity} until the consumer takes it.
module bch_encoder_seq
   import bch_encoder_seq_pkg::*;
#(
   parameter int CHUNK = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BCH_K-1:0] in_message,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BCH_N-1:0] out_codeword
);

   localparam int NCHUNK = BCH_K / CHUNK;
   localparam int CW     = $clog2(NCHUNK);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BCH_R-1:0] lfsr_q, lfsr_d, lfsr_step;
   logic [BCH_K-1:0] msg_q, msg_d;
   logic [BCH_N-1:0] cw_q, cw_d;
   logic [CHUNK-1:0] chunk_data;
   logic             last_chunk;

   assign chunk_data = msg_q[(BCH_K-1) - int'(cnt_q)*CHUNK -: CHUNK];
   assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

   bch_lfsr_step #(.CHUNK(CHUNK)) u_step (
      .state_i (lfsr_q),
      .data_i  (chunk_data),
      .state_o (lfsr_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)   state_d = ST_ENC;
         ST_ENC:  if (last_chunk) state_d = ST_DONE;
         ST_DONE: if (out_ready)  state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   // Codeword register is only written on the final chunk, so a partial result never shows.
   always_comb begin
      msg_d  = msg_q;
      cnt_d  = cnt_q;
      lfsr_d = lfsr_q;
      cw_d   = cw_q;
      if (state_q == ST_IDLE && in_valid) begin
         msg_d  = in_message;
         cnt_d  = '0;
         lfsr_d = '0;
      end else if (state_q == ST_ENC) begin
         lfsr_d = lfsr_step;
         cnt_d  = last_chunk ? cnt_q : cnt_q + CW'(1);
         if (last_chunk) cw_d = {msg_q, lfsr_step};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msg_q  <= '0;
         cnt_q  <= '0;
         lfsr_q <= '0;
         cw_q   <= '0;
      end else begin
         msg_q  <= msg_d;
         cnt_q  <= cnt_d;
         lfsr_q <= lfsr_d;
         cw_q   <= cw_d;
      end
   end

   assign out_codeword = cw_q;

endmodule

// File: tb/tb_bch_encoder_seq.sv
// Random and directed checks of bch_encoder_seq against a polynomial-division model
// and a GF(2^10) syndrome / Berlekamp-Massey corrector.
module tb_bch_encoder_seq;
   import bch_encoder_seq_pkg::*;

   localparam int W = 542;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_valid_a = 1'b0;
   logic           out_ready = 1'b0;
   logic           out_ready_a = 1'b0;
   logic [511:0]   in_message = '0;
   logic           in_ready, out_valid;
   logic [541:0]   out_codeword;
   logic           in_ready8, out_valid8, in_ready64, out_valid64;
   logic [541:0]   cw8, cw64;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int txn_cnt  = 0;
   int gexp [1023];
   int glog [1024];

   always #5 clk = ~clk;

   bch_encoder_seq u_dut (
      .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
      .in_message (in_message), .out_valid (out_valid), .out_ready (out_ready),
      .out_codeword (out_codeword)
   );
   bch_encoder_seq #(.CHUNK(8)) u_dut8 (
      .clk (clk), .rst_n (rst_n), .in_valid (in_valid_a), .in_ready (in_ready8),
      .in_message (in_message), .out_valid (out_valid8), .out_ready (out_ready_a),
      .out_codeword (cw8)
   );
   bch_encoder_seq #(.CHUNK(64)) u_dut64 (
      .clk (clk), .rst_n (rst_n), .in_valid (in_valid_a), .in_ready (in_ready64),
      .in_message (in_message), .out_valid (out_valid64), .out_ready (out_ready_a),
      .out_codeword (cw64)
   );

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Remainder of m(x)*x^30 divided by g(x), by long division.
   function automatic logic [29:0] ref_parity(input logic [511:0] m);
      logic [541:0] r;
      r = {m, 30'b0};
      for (int i = 541; i >= 30; i--)
         if (r[i]) r[i -: 31] = r[i -: 31] ^ BCH_GEN;
      return r[29:0];
   endfunction

   function automatic int gmul(input int a, input int b);
      if (a == 0 || b == 0) return 0;
      return gexp[(glog[a] + glog[b]) % 1023];
   endfunction

   function automatic int ginv(input int a);
      return gexp[(1023 - glog[a]) % 1023];
   endfunction

   // S_j = c(alpha^j), j = 1..6, packed 10 bits each
   function automatic logic [59:0] syndromes(input logic [541:0] c);
      logic [59:0] syn;
      int s;
      for (int j = 1; j <= 6; j++) begin
         s = 0;
         for (int p = 0; p < 542; p++)
            if (c[p]) s = s ^ gexp[(j * p) % 1023];
         syn[(j-1)*10 +: 10] = s[9:0];
      end
      return syn;
   endfunction

   function automatic logic [541:0] correct(input logic [541:0] c_in);
      logic [59:0]  syn;
      logic [541:0] c_out;
      int s [1:6];
      int cp [7];
      int bp [7];
      int tp [7];
      int ll, mm, bb, d, coef, val, nroot;
      syn = syndromes(c_in);
      for (int j = 1; j <= 6; j++) s[j] = int'(syn[(j-1)*10 +: 10]);
      for (int i = 0; i < 7; i++) begin
         cp[i] = 0;
         bp[i] = 0;
      end
      cp[0] = 1; bp[0] = 1; ll = 0; mm = 1; bb = 1;
      for (int n = 0; n < 6; n++) begin
         d = s[n+1];
         for (int i = 1; i <= ll; i++) d = d ^ gmul(cp[i], s[n+1-i]);
         if (d == 0) begin
            mm++;
         end else begin
            coef = gmul(d, ginv(bb));
            tp = cp;
            for (int i = mm; i < 7; i++) cp[i] = cp[i] ^ gmul(coef, bp[i-mm]);
            if (2 * ll <= n) begin
               ll = n + 1 - ll;
               bp = tp;
               bb = d;
               mm = 1;
            end else begin
               mm++;
            end
         end
      end
      c_out = c_in;
      nroot = 0;
      for (int p = 0; p < 542; p++) begin
         val = 0;
         for (int i = 0; i <= ll; i++)
            val = val ^ gmul(cp[i], gexp[(((1023 - p) % 1023) * i) % 1023]);
         if (val == 0) begin
            c_out[p] = ~c_out[p];
            nroot++;
         end
      end
      if (nroot != ll) c_out = c_in;
      return c_out;
   endfunction

   // Called one time unit after an edge with the main encoder idle.
   task automatic encode_one(input logic [511:0] msg, input int stall, input bit chain,
                             input logic [511:0] next_msg, output logic [541:0] cw);
      int n;
      in_message = msg;
      in_valid   = 1'b1;
      @(posedge clk); #1;
      in_valid   = 1'b0;
      in_message = rand512();
      check_eq("accept", W'(in_ready), W'(1'b0));
      n = 0;
      while (!out_valid && n < 200) begin
         in_valid   = 1'($urandom_range(0, 1));
         in_message = rand512();
         @(posedge clk); #1;
         n++;
      end
      check_eq("latency", W'(n + 1), W'(17));
      cw = out_codeword;
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         check_eq("hold_valid", W'(out_valid), W'(1'b1));
         check_eq("hold_cw", out_codeword, cw);
      end
      out_ready  = 1'b1;
      in_valid   = chain;
      in_message = chain ? next_msg : rand512();
      @(posedge clk); #1;
      out_ready  = 1'b0;
      check_eq("handoff", W'({in_ready, out_valid}), W'(2'b10));
      if (!chain) in_valid = 1'b0;
      txn_cnt++;
      $display("txn %0d lat=%0d stall=%0d parity=%h", txn_cnt, n + 1, stall, cw[29:0]);
   endtask

   task automatic encode_alt(input logic [511:0] msg, input logic [541:0] cw32);
      int n, lat8, lat64;
      in_message = msg;
      in_valid_a = 1'b1;
      @(posedge clk); #1;
      in_valid_a = 1'b0;
      n = 0; lat8 = 0; lat64 = 0;
      while ((lat8 == 0 || lat64 == 0) && n < 200) begin
         in_message = rand512();
         @(posedge clk); #1;
         n++;
         if (out_valid8 && lat8 == 0)   lat8 = n + 1;
         if (out_valid64 && lat64 == 0) lat64 = n + 1;
      end
      check_eq("lat8", W'(lat8), W'(65));
      check_eq("lat64", W'(lat64), W'(9));
      check_eq("cw8", cw8, cw32);
      check_eq("cw64", cw64, cw32);
      out_ready_a = 1'b1;
      @(posedge clk); #1;
      out_ready_a = 1'b0;
      check_eq("alt_idle", W'({in_ready8, in_ready64, out_valid8, out_valid64}), W'(4'b1100));
      txn_cnt++;
      $display("txn %0d alt lat8=%0d lat64=%0d parity=%h", txn_cnt, lat8, lat64, cw8[29:0]);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [541:0] cw, bad;
      logic [511:0] m, m2;
      logic [59:0]  syn;
      int v, nerr, pos, tries;

      v = 1;
      glog[0] = 0;
      for (int i = 0; i < 1023; i++) begin
         gexp[i] = v;
         glog[v] = i;
         v = v << 1;
         if (v >= 1024) v = v ^ 'h409;
      end

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ready", W'(in_ready), W'(1'b1));
      check_eq("rst_valid", W'(out_valid), W'(1'b0));
      check_eq("rst_cw", out_codeword, '0);
      rst_n = 1'b1;

      encode_one('0, 0, 1'b0, '0, cw);
      check_eq("zero_cw", cw, '0);

      m = 512'd1;
      encode_one(m, 0, 1'b0, '0, cw);
      check_eq("one_parity", W'(cw[29:0]), W'(BCH_GEN[29:0]));
      check_eq("one_msg", W'(cw[541:30]), W'(m));

      m = '0;
      m[511] = 1'b1;
      encode_one(m, 0, 1'b0, '0, cw);
      check_eq("top_cw", cw, {m, ref_parity(m)});

      // Backpressure, then a message queued at the output-transfer edge
      m  = rand512();
      m2 = rand512();
      encode_one(m, 20, 1'b1, m2, cw);
      check_eq("bp_cw", cw, {m, ref_parity(m)});
      encode_one(m2, 0, 1'b0, '0, cw);
      check_eq("bp_next_cw", cw, {m2, ref_parity(m2)});

      // Reset in the middle of encoding
      in_message = rand512();
      in_valid   = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_ready", W'(in_ready), W'(1'b1));
      check_eq("mid_rst_valid", W'(out_valid), W'(1'b0));
      check_eq("mid_rst_cw", out_codeword, '0);
      @(posedge clk); #1;
      check_eq("mid_rst_hold", W'({in_ready, out_valid}), W'(2'b10));
      rst_n = 1'b1;
      m = rand512();
      encode_one(m, 0, 1'b0, '0, cw);
      check_eq("post_rst_cw", cw, {m, ref_parity(m)});

      for (int k = 0; k < 4; k++) begin
         m = (k == 0) ? '0 : (k == 1) ? 512'd1 : rand512();
         if (k == 2) begin
            m = '0;
            m[511] = 1'b1;
         end
         encode_one(m, 0, 1'b0, '0, cw);
         check_eq("alt_ref_cw", cw, {m, ref_parity(m)});
         encode_alt(m, cw);
      end

      for (int k = 0; k < 1000; k++) begin
         m = rand512();
         encode_one(m, int'($urandom_range(0, 3)), 1'b0, '0, cw);
         check_eq("rand_cw", cw, {m, ref_parity(m)});
         syn = syndromes(cw);
         check_eq("syndromes", W'(syn[49:0]), '0);
         check_eq("clean_corr", correct(cw), cw);
         nerr  = int'($urandom_range(1, 3));
         bad   = cw;
         tries = 0;
         while ($countones(bad ^ cw) != nerr && tries < 100) begin
            pos = int'($urandom_range(0, 541));
            bad[pos] = ~bad[pos];
            tries++;
         end
         check_eq("err_corr", correct(bad), cw);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
